// File: rtl/reg_wb_pkg.sv
// Shared constants and the queue entry type for the register-file writeback path.
package reg_wb_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One pending register write.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
    logic              valid;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_match.sv
// Youngest-match search over the pending writeback entries for one read port.
// Walks entries from head (oldest) toward tail-1 (youngest) so the last hit wins.
module reg_wb_match
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]         ents,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [REG_AW-1:0]             addr,
  output logic                          hit,
  output logic [REG_DW-1:0]             data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Age-ordered scan; only valid entries can match, and r0 never matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ents[idx].valid && ents[idx].addr == addr && addr != REG_ZERO) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end
endmodule

// File: rtl/reg_wb_queue.sv
// In-order writeback queue driving the 32x32 register file write port.
// Optional read bypass of pending writes: define REG_WB_BYPASS_EN.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_valid_i,
  output logic                     wb_ready_o,
  input  logic [AW-1:0]            wb_addr_i,
  input  logic [DW-1:0]            wb_data_i,
  input  logic                     drain_hold_i,
  output logic [AW-1:0]            RDaddr_o,
  output logic [DW-1:0]            RDdata_o,
  output logic                     RegWrite_o,
  input  logic [AW-1:0]            RSaddr_i,
  input  logic [AW-1:0]            RTaddr_i,
  output logic                     RS_hit_o,
  output logic [DW-1:0]            RS_data_o,
  output logic                     RT_hit_o,
  output logic [DW-1:0]            RT_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage uses the package widths; AW/DW default to them.
  wb_entry_t [DEPTH-1:0] q;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  push, pop, nonempty;

  assign nonempty   = (count != '0);
  assign wb_ready_o = (count < CW'(DEPTH));
  // r0 writes complete the handshake but are dropped.
  assign push       = wb_valid_i && wb_ready_o && (wb_addr_i != REG_ZERO);
  // Held low during reset so the discarded head is not written on the reset edge.
  assign RegWrite_o = rst_i && nonempty && !drain_hold_i;
  assign pop        = RegWrite_o;
  assign RDaddr_o   = nonempty ? q[head].addr : '0;
  assign RDdata_o   = nonempty ? q[head].data : '0;
  assign count_o    = count;

  // Queue state: pointers, occupancy and entry storage.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push) begin
        q[tail] <= '{addr: wb_addr_i, data: wb_data_i, valid: 1'b1};
        tail    <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef REG_WB_BYPASS_EN
  reg_wb_match #(.DEPTH(DEPTH)) u_rs_match (
    .ents (q),
    .head (head),
    .addr (RSaddr_i),
    .hit  (RS_hit_o),
    .data (RS_data_o)
  );

  reg_wb_match #(.DEPTH(DEPTH)) u_rt_match (
    .ents (q),
    .head (head),
    .addr (RTaddr_i),
    .hit  (RT_hit_o),
    .data (RT_data_o)
  );
`else
  // Without bypass the consumer stalls reads until the queue is empty.
  logic unused_byp;
  assign unused_byp = ^{RSaddr_i, RTaddr_i, q};
  assign RS_hit_o   = 1'b0;
  assign RS_data_o  = '0;
  assign RT_hit_o   = 1'b0;
  assign RT_data_o  = '0;
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue; bypass expectations follow REG_WB_BYPASS_EN.
module tb_reg_wb_queue;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        drain_hold_i;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic [4:0]  RSaddr_i, RTaddr_i;
  logic        RS_hit_o, RT_hit_o;
  logic [31:0] RS_data_o, RT_data_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;

`ifdef REG_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  reg_wb_queue dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb_valid_i   (wb_valid_i),
    .wb_ready_o   (wb_ready_o),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .drain_hold_i (drain_hold_i),
    .RDaddr_o     (RDaddr_o),
    .RDdata_o     (RDdata_o),
    .RegWrite_o   (RegWrite_o),
    .RSaddr_i     (RSaddr_i),
    .RTaddr_i     (RTaddr_i),
    .RS_hit_o     (RS_hit_o),
    .RS_data_o    (RS_data_o),
    .RT_hit_o     (RT_hit_o),
    .RT_data_o    (RT_data_o),
    .count_o      (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled and away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = v;
    wb_addr_i  = a;
    wb_data_i  = d;
    #1;
  endtask

  logic [4:0] exp_hd [4];

  initial begin
    rst_i = 1'b0; drain_hold_i = 1'b0; RSaddr_i = '0; RTaddr_i = '0;
    drive(1'b0, '0, '0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_regwrite", 32'(RegWrite_o), 0);
    chk("rst_rdaddr", 32'(RDaddr_o), 0);
    chk("rst_rddata", RDdata_o, 0);
    chk("rst_ready", 32'(wb_ready_o), 1);

    // Single write, minimum latency.
    drive(1'b1, 5'd5, 32'h9);
    tick();
    drive(1'b0, '0, '0);
    chk("t1_regwrite", 32'(RegWrite_o), 1);
    chk("t1_rdaddr", 32'(RDaddr_o), 5);
    chk("t1_rddata", RDdata_o, 32'h9);
    chk("t1_count", 32'(count_o), 1);
    tick();
    chk("t1_regwrite_after", 32'(RegWrite_o), 0);
    chk("t1_count_after", 32'(count_o), 0);

    // Fill under hold, reject when full, then drain in order.
    drain_hold_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    drive(1'b1, 5'd9, 32'h999);
    chk("t2_count_full", 32'(count_o), 4);
    chk("t2_ready_full", 32'(wb_ready_o), 0);
    chk("t2_held_nowrite", 32'(RegWrite_o), 0);
    tick();
    chk("t2_count_reject", 32'(count_o), 4);
    drive(1'b0, '0, '0);
    drain_hold_i = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_we", 32'(RegWrite_o), 1);
      chk("t2_drain_addr", 32'(RDaddr_o), 32'(i));
      chk("t2_drain_data", RDdata_o, 32'h100 + 32'(i));
      tick();
    end
    chk("t2_empty", 32'(count_o), 0);
    chk("t2_empty_we", 32'(RegWrite_o), 0);

    // r0 write: handshake but no storage.
    drive(1'b1, 5'd0, 32'hDEAD);
    chk("t3_ready", 32'(wb_ready_o), 1);
    tick();
    drive(1'b0, '0, '0);
    chk("t3_count", 32'(count_o), 0);
    chk("t3_we", 32'(RegWrite_o), 0);
    tick();
    chk("t3_we_later", 32'(RegWrite_o), 0);

    // Bypass: youngest of two same-address writes.
    drain_hold_i = 1'b1;
    drive(1'b1, 5'd7, 32'h11); tick();
    drive(1'b1, 5'd7, 32'h22); tick();
    drive(1'b0, '0, '0);
    RSaddr_i = 5'd7; RTaddr_i = 5'd8;
    #1;
    chk("t4_rs_hit", 32'(RS_hit_o), 32'(BYP));
    chk("t4_rs_data", RS_data_o, BYP ? 32'h22 : 32'h0);
    chk("t4_rt_hit", 32'(RT_hit_o), 0);
    chk("t4_rt_data", RT_data_o, 0);
    RTaddr_i = 5'd0;
    #1;
    chk("t4_r0_nohit", 32'(RT_hit_o), 0);
    drain_hold_i = 1'b0;
    #1;
    chk("t4_d0_addr", 32'(RDaddr_o), 7);
    chk("t4_d0_data", RDdata_o, 32'h11);
    chk("t4_rs_hit_drain", 32'(RS_hit_o), 32'(BYP));
    chk("t4_rs_data_drain", RS_data_o, BYP ? 32'h22 : 32'h0);
    tick();
    chk("t4_d1_data", RDdata_o, 32'h22);
    chk("t4_rs_head", RS_data_o, BYP ? 32'h22 : 32'h0);
    tick();
    chk("t4_rs_gone", 32'(RS_hit_o), 0);
    RSaddr_i = '0;

    // Full with continuous valid: ready ignores the same-cycle pop, so the
    // first cycle only drains and occupancy then settles at DEPTH-1 with one
    // accept and one write per cycle.
    drain_hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'h200 + 32'(i));
      tick();
    end
    drive(1'b1, 5'd20, 32'h300);
    drain_hold_i = 1'b0;
    #1;
    chk("t5_full_ready", 32'(wb_ready_o), 0);
    chk("t5_full_we", 32'(RegWrite_o), 1);
    chk("t5_full_addr", 32'(RDaddr_o), 10);
    tick();
    chk("t5_count_first", 32'(count_o), 3);
    exp_hd[0] = 5'd11; exp_hd[1] = 5'd12; exp_hd[2] = 5'd13; exp_hd[3] = 5'd20;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(20 + k), 32'h300 + 32'(k));
      chk("t5_ready", 32'(wb_ready_o), 1);
      chk("t5_we", 32'(RegWrite_o), 1);
      chk("t5_addr", 32'(RDaddr_o), 32'(exp_hd[k]));
      tick();
      chk("t5_count", 32'(count_o), 3);
    end
    drive(1'b0, '0, '0);
    for (int k = 1; k < 4; k++) begin
      chk("t5_tail_addr", 32'(RDaddr_o), 32'(20 + k));
      chk("t5_tail_data", RDdata_o, 32'h300 + 32'(k));
      tick();
    end
    chk("t5_empty", 32'(count_o), 0);

    // Reset with three pending entries: none may ever be written.
    drain_hold_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 32'h400 + 32'(i));
      tick();
    end
    drive(1'b0, '0, '0);
    chk("t6_pending", 32'(count_o), 3);
    drain_hold_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("t6_we_in_reset", 32'(RegWrite_o), 0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("t6_count", 32'(count_o), 0);
    chk("t6_we", 32'(RegWrite_o), 0);
    chk("t6_rdaddr", 32'(RDaddr_o), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_write", 32'(RegWrite_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
